// File: rtl/aes_kexp_seq.sv
// Iterative AES key expansion: one schedule word per cycle through a single SubWord path.
// Build option: define AES_KEXP_ZEROIZE_EN to force KExp to zero whenever Valid is low.
// Key_in byte 0 sits in bits [32*NK-1 -: 8]. KExp word 0 occupies the top 32 bits, and word W-1 the bottom 32 bits.
module aes_kexp_seq #(
   parameter int NB = 4,
   parameter int NK = 4,
   parameter int NR = NK + 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [32*NK-1:0]           Key_in,
   input  logic                       Start,
   output logic                       Ready,
   output logic                       Valid,
   output logic [32*NB*(NR+1)-1:0]    KExp
);
   localparam int unsigned W  = NB * (NR + 1);
   localparam int unsigned IW = $clog2(W);
   localparam int unsigned MW = $clog2(NK);

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   i_q, i_d;
   logic [MW-1:0]   mod_q, mod_d;
   logic [7:0]      rcon_q, rcon_d;
   logic [31:0]     w_q [W];
   logic [31:0]     w_d [W];
   logic            accept, last;
   logic [31:0]     prev, sub_in, sub_out, temp;
   logic            is_rcon, is_sub4;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = '0;
      aa = a;
      bb = b;
      for (int unsigned k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // The S-box uses the multiplicative inverse x^254 in GF(2^8), followed by the affine map. Zero maps to zero.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, inv;
      sq  = x;
      inv = 8'h01;
      for (int unsigned k = 0; k < 7; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   always_comb begin
      accept = Start && (state_q != S_EXPAND);
      last   = (state_q == S_EXPAND) && (i_q == IW'(W - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (accept) state_d = S_EXPAND;
         S_EXPAND:       if (last)   state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Ready = (state_q != S_EXPAND);
      Valid = (state_q == S_DONE);
      KExp  = '0;
      for (int unsigned j = 0; j < W; j++) KExp[32*(W-1-j) +: 32] = w_q[j];
`ifdef AES_KEXP_ZEROIZE_EN
      if (!Valid) KExp = '0;
`endif
   end

   // The rotate-or-pass mux in front of SubWord lets both substitution cases share one S-box word path.
   always_comb begin
      prev    = w_q[i_q - IW'(1)];
      is_rcon = (mod_q == '0);
      is_sub4 = (NK == 8) && (mod_q == MW'(4));
      sub_in  = is_rcon ? {prev[23:0], prev[31:24]} : prev;
      sub_out = sub_word(sub_in);
      if (is_rcon)      temp = sub_out ^ {rcon_q, 24'h0};
      else if (is_sub4) temp = sub_out;
      else              temp = prev;

      w_d    = w_q;
      i_d    = i_q;
      mod_d  = mod_q;
      rcon_d = rcon_q;
      if (accept) begin
         for (int unsigned j = 0; j < NK; j++) w_d[j] = Key_in[32*(NK-1-j) +: 32];
         i_d    = IW'(NK);
         mod_d  = '0;
         rcon_d = 8'h01;
      end else if (state_q == S_EXPAND) begin
         w_d[i_q] = w_q[i_q - IW'(NK)] ^ temp;
         i_d      = i_q + 1'b1;
         mod_d    = (mod_q == MW'(NK - 1)) ? '0 : mod_q + 1'b1;
         if (is_rcon) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q    <= '0;
         mod_q  <= '0;
         rcon_q <= 8'h01;
         w_q    <= '{default: '0};
      end else begin
         i_q    <= i_d;
         mod_q  <= mod_d;
         rcon_q <= rcon_d;
         w_q    <= w_d;
      end
   end
endmodule

// File: tb/tb_aes_kexp_seq.sv
// Scoreboard bench for aes_kexp_seq. It runs three instances (NK=4/6/8) and checks them against a table-driven key-schedule model.
// Honours AES_KEXP_ZEROIZE_EN the same way the design does.
module tb_aes_kexp_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         st4 = 1'b0, st6 = 1'b0, st8 = 1'b0;
   logic [127:0] k4 = '0;
   logic [191:0] k6 = '0;
   logic [255:0] k8 = '0;
   logic         rdy4, rdy6, rdy8, vld4, vld6, vld8;
   logic [44*32-1:0] kx4;
   logic [52*32-1:0] kx6;
   logic [60*32-1:0] kx8;
   logic [1919:0] kp [3];

   assign kp[0] = {kx4, 512'b0};
   assign kp[1] = {kx6, 256'b0};
   assign kp[2] = kx8;

   aes_kexp_seq #(.NB(4), .NK(4), .NR(10)) u_dut4 (
      .clk(clk), .rst(rst), .Key_in(k4), .Start(st4), .Ready(rdy4), .Valid(vld4), .KExp(kx4));
   aes_kexp_seq #(.NB(4), .NK(6), .NR(12)) u_dut6 (
      .clk(clk), .rst(rst), .Key_in(k6), .Start(st6), .Ready(rdy6), .Valid(vld6), .KExp(kx6));
   aes_kexp_seq #(.NB(4), .NK(8), .NR(14)) u_dut8 (
      .clk(clk), .rst(rst), .Key_in(k8), .Start(st8), .Ready(rdy8), .Valid(vld8), .KExp(kx8));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   logic [127:0] sbox_rows [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef struct {
      logic [1919:0] w;
      int            ec;
   } exp_t;
   exp_t qs [3][$];
   bit   vprev [3] = '{0, 0, 0};

   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [127:0] r;
      r = sbox_rows[x[7:4]];
      return r[127-8*x[3:0] -: 8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
   endfunction

   function automatic logic [31:0] word(input logic [1919:0] v, input int j);
      return v[1919-32*j -: 32];
   endfunction

   // The key is left-aligned in 256 bits. The result is packed word 0 first and zero-filled past W-1.
   function automatic logic [1919:0] model(input int nk, input logic [255:0] key);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [79:0]   rct;
      logic [1919:0] r;
      int            nw;
      rct = 80'h01020408102040801b36;
      nw  = 4 * (nk + 7);
      for (int j = 0; j < 60; j++) w[j] = '0;
      for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]});
            t[31:24] = t[31:24] ^ rct[79-8*(i/nk-1) -: 8];
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int j = 0; j < 60; j++) r[1919-32*j -: 32] = w[j];
      return r;
   endfunction

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [1919:0] act, input logic [1919:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         for (int j = 0; j < 60; j++)
            if (word(act, j) !== word(exp, j)) begin
               $display("FAIL %s word%0d got=%h exp=%h", name, j, word(act, j), word(exp, j));
               break;
            end
      end
   endtask

   function automatic logic getv(input int d);
      case (d)
         0:       return vld4;
         1:       return vld6;
         default: return vld8;
      endcase
   endfunction

   function automatic logic getr(input int d);
      case (d)
         0:       return rdy4;
         1:       return rdy6;
         default: return rdy8;
      endcase
   endfunction

   task automatic mon(input int d, input logic v, input logic [1919:0] kx);
      exp_t e;
      if (v && !vprev[d]) begin
         if (qs[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid dut%0d got=1 exp=0", d);
         end else begin
            e = qs[d].pop_front();
            chk_vec($sformatf("schedule_dut%0d", d), kx, e.w);
            chk_int($sformatf("latency_dut%0d", d), cyc, e.ec);
         end
      end
`ifdef AES_KEXP_ZEROIZE_EN
      if (!v) chk_vec($sformatf("zeroize_dut%0d", d), kx, '0);
`endif
      vprev[d] = v;
   endtask

   always @(negedge clk) begin
      mon(0, vld4, kp[0]);
      mon(1, vld6, kp[1]);
      mon(2, vld8, kp[2]);
   end

   // The start request is driven for one clock edge. The bench states whether the DUT should accept it.
   task automatic start_req(input int d, input logic [255:0] key, input bit acc);
      int nk;
      exp_t e;
      nk = 4 + 2 * d;
      @(negedge clk);
      case (d)
         0:       begin k4 = key[255 -: 128]; st4 = 1'b1; end
         1:       begin k6 = key[255 -: 192]; st6 = 1'b1; end
         default: begin k8 = key;             st8 = 1'b1; end
      endcase
      chk_int($sformatf("ready_at_start_dut%0d", d), int'(getr(d)), int'(acc));
      if (acc) begin
         e.w  = model(nk, key);
         e.ec = cyc + 1 + 3 * nk + 28;
         qs[d].push_back(e);
      end
      @(negedge clk);
      st4 = 1'b0; st6 = 1'b0; st8 = 1'b0;
   endtask

   task automatic wait_valid(input int d, input int budget);
      int n;
      n = 0;
      while (!getv(d) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk_int($sformatf("valid_seen_dut%0d", d), int'(getv(d)), 1);
   endtask

   localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   initial begin
      logic [1919:0] m;
      logic [255:0]  kr;
      exp_t          e;
      int            c0;

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk_int($sformatf("reset_ready_dut%0d", d), int'(getr(d)), 1);
         chk_int($sformatf("reset_valid_dut%0d", d), int'(getv(d)), 0);
         chk_vec($sformatf("reset_kexp_dut%0d", d), kp[d], '0);
      end
      rst = 1'b0;

      // The key is loaded first, the schedule is partially visible, a Start during EXPAND is ignored, and the full result follows.
      m = model(4, K1);
      start_req(0, K1, 1'b1);
`ifndef AES_KEXP_ZEROIZE_EN
      chk_vec("key_load", {kp[0][1919 -: 128], 1792'b0}, {K1[255 -: 128], 1792'b0});
      chk_int("word4_unwritten", int'(word(kp[0], 4) == 32'h0), 1);
      repeat (10) @(negedge clk);
      chk_vec("partial_w13", {word(kp[0], 13), 1888'b0}, {word(m, 13), 1888'b0});
      chk_int("word14_unwritten", int'(word(kp[0], 14) == 32'h0), 1);
`else
      repeat (10) @(negedge clk);
`endif
      start_req(0, {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0}, 1'b0);
      wait_valid(0, 60);
      chk_int("t1_w4", int'(word(kp[0], 4) == 32'ha0fafe17), 1);
      chk_int("t1_w43", int'(word(kp[0], 43) == 32'hb6630ca6), 1);

      start_req(1, K2, 1'b1);
      wait_valid(1, 70);
      chk_int("t2_w6", int'(word(kp[1], 6) == 32'hfe0c91f7), 1);
      chk_int("t2_w51", int'(word(kp[1], 51) == 32'h01002202), 1);

      start_req(2, K3, 1'b1);
      wait_valid(2, 80);
      chk_int("t3_w8", int'(word(kp[2], 8) == 32'h9ba35411), 1);
      chk_int("t3_w59", int'(word(kp[2], 59) == 32'h706c631e), 1);

      // A reset in the middle of an expansion clears every output at once. A restart with the same key then completes.
      start_req(0, K1, 1'b1);
      repeat (19) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_int("abort_ready", int'(rdy4), 1);
      chk_int("abort_valid", int'(vld4), 0);
      chk_vec("abort_kexp", kp[0], '0);
      chk_int("abort_valid_dut2", int'(vld8), 0);
      qs[0].delete();
      @(negedge clk);
      rst = 1'b0;
      start_req(0, K1, 1'b1);
      wait_valid(0, 60);
      chk_int("t5_w43", int'(word(kp[0], 43) == 32'hb6630ca6), 1);

      // Holding Start high in DONE starts another expansion, and the second key is sampled on that accepting edge.
      @(negedge clk);
      kr = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
      k4 = kr[255 -: 128];
      st4 = 1'b1;
      chk_int("hold_ready_first", int'(rdy4), 1);
      c0 = cyc + 1;
      e.w = model(4, kr);
      e.ec = c0 + 40;
      qs[0].push_back(e);
      repeat (41) @(negedge clk);
      kr = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
      k4 = kr[255 -: 128];
      chk_int("hold_ready_second", int'(rdy4), 1);
      e.w = model(4, kr);
      e.ec = c0 + 81;
      qs[0].push_back(e);
      @(negedge clk);
      st4 = 1'b0;
      wait_valid(0, 60);

      for (int r = 0; r < 2; r++)
         for (int d = 0; d < 3; d++) begin
            kr = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            if (d == 0) kr[127:0] = '0;
            if (d == 1) kr[63:0] = '0;
            start_req(d, kr, 1'b1);
            wait_valid(d, 80);
         end

      @(negedge clk);
      for (int d = 0; d < 3; d++) chk_int($sformatf("queue_empty_dut%0d", d), qs[d].size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
